// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze with timeout, load-use stall, taken-branch flush.
// Optional perf counters (StallCnt_o, FlushCnt_o) enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_rs1_i,
  input  logic [4:0]  ID_rs2_i,
  input  logic [4:0]  EX_rd_i,
  input  logic        EX_MemRead_i,
  input  logic        ID_BranchTaken_i,
  input  logic        MemReq_i,
  input  logic        MemAck_i,
  output logic        PCWrite_o,
  output logic        IFID_Stall_o,
  output logic        IFID_Flush_o,
  output logic        IDEX_Bubble_o,
  output logic        Freeze_o,
  output logic        MemTimeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o
`endif
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  // Timeout fires when the incremented count would reach TIMEOUT.
  localparam logic [7:0] TimeoutM1 = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       mem_freeze;
  logic       load_use;
  logic       timed_out;

  always_comb begin
    mem_freeze = ((state_q == StRun) && MemReq_i && !MemAck_i) ||
                 ((state_q == StMemWait) && !MemAck_i);
    load_use   = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                 ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));
    timed_out  = mem_freeze && (wait_q >= TimeoutM1);
  end

  // Output decode: freeze (or error) > load-use > branch flush.
  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Stall_o  = 1'b0;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    Freeze_o      = 1'b0;
    if ((state_q == StError) || mem_freeze) begin
      PCWrite_o    = 1'b0;
      IFID_Stall_o = 1'b1;
      Freeze_o     = 1'b1;
    end else if (load_use) begin
      PCWrite_o     = 1'b0;
      IFID_Stall_o  = 1'b1;
      IDEX_Bubble_o = 1'b1;
    end else if (ID_BranchTaken_i) begin
      IFID_Flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    if (Freeze_o) begin
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    end else begin
      wait_d = 8'd0;
    end
    case (state_q)
      StRun: begin
        if (timed_out) begin
          state_d   = StError;
          timeout_d = 1'b1;
        end else if (mem_freeze) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (MemAck_i) begin
          state_d = StRun;
        end else if (timed_out) begin
          state_d   = StError;
          timeout_d = 1'b1;
        end
      end
      StError: state_d = StError;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign MemTimeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!PCWrite_o)   stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IFID_Flush_o) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4); perf counters checked when HAZARD_PERF_CNT_EN is set.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       mem_read, br_taken, mem_req, mem_ack;
  logic       pc_write, ifid_stall, ifid_flush, idex_bubble, freeze, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ID_rs1_i        (rs1),
    .ID_rs2_i        (rs2),
    .EX_rd_i         (rd),
    .EX_MemRead_i    (mem_read),
    .ID_BranchTaken_i(br_taken),
    .MemReq_i        (mem_req),
    .MemAck_i        (mem_ack),
    .PCWrite_o       (pc_write),
    .IFID_Stall_o    (ifid_stall),
    .IFID_Flush_o    (ifid_flush),
    .IDEX_Bubble_o   (idex_bubble),
    .Freeze_o        (freeze),
    .MemTimeout_o    (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt_o      (stall_cnt),
    .FlushCnt_o      (flush_cnt)
`endif
  );

  // Expected output vectors {PCWrite, IFID_Stall, IFID_Flush, IDEX_Bubble, Freeze, MemTimeout}
  localparam logic [5:0] Idle = 6'b100000;
  localparam logic [5:0] Lu   = 6'b010100;
  localparam logic [5:0] Frz  = 6'b010010;
  localparam logic [5:0] Fl   = 6'b101000;
  localparam logic [5:0] Err  = 6'b010011;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [5:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic r, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic mr, input logic bt, input logic rq,
                     input logic ak, input logic [5:0] exp);
    logic [5:0] e;
    rst = r; rs1 = s1; rs2 = s2; rd = d;
    mem_read = mr; br_taken = bt; mem_req = rq; mem_ack = ak;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq(tag, {26'd0, pc_write, ifid_stall, ifid_flush, idex_bubble, freeze, mem_timeout},
             {26'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0;
    mem_read = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    cyc("reset_idle", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, Idle);
    // Load-use on rs2, then clear
    cyc("lu_rs2",     0, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, Lu);
    cyc("lu_after",   0, 5'd1, 5'd5, 5'd5, 0, 0, 0, 0, Idle);
    // Load-use with branch: bubble wins, then branch flush
    cyc("lu_br",      0, 5'd7, 5'd2, 5'd7, 1, 1, 0, 0, Lu);
    cyc("br_held",    0, 5'd7, 5'd2, 5'd7, 0, 1, 0, 0, Fl);
`ifdef HAZARD_PERF_CNT_EN
    cyc("perf_idle",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, Idle);
    check_eq("stall_cnt", stall_cnt, 32'd2);
    check_eq("flush_cnt", flush_cnt, 32'd1);
`endif
    cyc("x0_no_lu",   0, 5'd0, 5'd3, 5'd0, 1, 0, 0, 0, Idle);
    cyc("rd_mismatch",0, 5'd4, 5'd6, 5'd9, 1, 0, 0, 0, Idle);
    cyc("no_memread", 0, 5'd9, 5'd6, 5'd9, 0, 0, 0, 0, Idle);
    cyc("lu_rs1",     0, 5'd31, 5'd6, 5'd31, 1, 0, 0, 0, Lu);
    cyc("req_ack",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, Idle);
    // Freeze outranks load-use
    cyc("frz_vs_lu",  0, 5'd8, 5'd0, 5'd8, 1, 1, 1, 0, Frz);
    cyc("frz_ack",    0, 5'd8, 5'd0, 5'd8, 1, 1, 1, 1, Lu);
    cyc("after_ack",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, Idle);
    // Three-cycle freeze with branch held; ack on the cycle the count would hit TIMEOUT
    for (int i = 0; i < 3; i++) cyc("frz_br", 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, Frz);
    cyc("ack_flush",  0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, Fl);
    cyc("post_ack",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, Idle);
    // Timeout: four freeze cycles, error from the fifth
    for (int i = 0; i < 4; i++) cyc("to_frz", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, Frz);
    cyc("to_err",     0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, Err);
    cyc("err_ack",    0, 5'd3, 5'd0, 5'd3, 1, 1, 1, 1, Err);
    cyc("err_idle_in",0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, Err);
    cyc("err_rst",    1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, Err);
    cyc("rst_idle",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, Idle);
    // Reset in the middle of MEM_WAIT
    cyc("mw_frz",     0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, Frz);
    cyc("mw_rst",     1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, Frz);
    cyc("mw_run",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, Fl);
    if (exp_q.size() != 0) check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
